// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive path with byte FIFO.
//               Clk is the baud clock: one Rx bit is sampled per rising edge,
//               with no oversampling. Frame format is start(0), DATA_BITS
//               data bits MSB-first, an optional even-parity bit and
//               STOP_BITS stop bits(1). Good bytes are buffered in a FIFO
//               that the host drains one byte per Read_Done strobe.
//
//               Ports:
//                 Clk           baud clock, all logic on posedge
//                 Rst           synchronous active-high reset
//                 Rx            serial input, idle high
//                 Read_Done     pop strobe, one byte per cycle it is high
//                 Data_Out      byte from the most recent pop (registered)
//                 Data_Rdy      1-cycle pulse in the cycle Data_Out updates
//                 Rx_Error      [0]=break [1]=parity [2]=frame, last frame
//                 RTS           1 while the FIFO is not full
//                 FIFO_Empty    FIFO count is zero
//                 FIFO_Full     FIFO count above half depth
//                 FIFO_Overflow sticky: a good byte was dropped at full
//
//               Build option UART_RX_SYNC_EN: when defined, Rx passes through
//               a 2-flop synchronizer (reset to 1) ahead of the receiver,
//               delaying every Rx-relative event by 2 Clk.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_BIT = 1,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Read_Done,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 RTS,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow
);

    localparam int c_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = c_ADDR_W + 1;
    localparam int c_MAX_BIT = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int c_BIT_W   = $clog2(c_MAX_BIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_PARITY  = 3'd2,
        ST_STOP    = 3'd3,
        ST_END     = 3'd4,
        ST_BRKWAIT = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Rx conditioning
    // ------------------------------------------------------------------
    logic w_rx;

`ifdef UART_RX_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= Rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;
`else
    assign w_rx = Rx;
`endif

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_BIT_W-1:0]   r_bitcnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_allzero;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_bitcnt == c_BIT_W'(DATA_BITS - 1)) begin
                    w_state_nxt = (PARITY_BIT != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (r_bitcnt == c_BIT_W'(STOP_BITS - 1)) begin
                    w_state_nxt = ST_END;
                end
            end
            ST_END: begin
                // Rx is deliberately not looked at here: a low level in this
                // cycle is never taken as a start bit.
                w_state_nxt = r_allzero ? ST_BRKWAIT : ST_IDLE;
            end
            ST_BRKWAIT: begin
                if (w_rx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit counter, shift register and per-frame error collection.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_bitcnt  <= '0;
            r_shreg   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_allzero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx) begin
                        r_bitcnt  <= '0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                        // The start bit itself is already a zero.
                        r_allzero <= 1'b1;
                    end
                end
                ST_DATA: begin
                    r_shreg   <= {r_shreg[DATA_BITS-2:0], w_rx};
                    r_allzero <= r_allzero & ~w_rx;
                    // Clearing at the last data bit also primes the stop count.
                    if (r_bitcnt == c_BIT_W'(DATA_BITS - 1)) begin
                        r_bitcnt <= '0;
                    end else begin
                        r_bitcnt <= r_bitcnt + c_BIT_W'(1);
                    end
                end
                ST_PARITY: begin
                    // Even parity: the parity bit equals the XOR of the data.
                    r_perr    <= (w_rx != ^r_shreg);
                    r_allzero <= r_allzero & ~w_rx;
                end
                ST_STOP: begin
                    if (!w_rx) begin
                        r_ferr <= 1'b1;
                    end
                    r_allzero <= r_allzero & ~w_rx;
                    r_bitcnt  <= r_bitcnt + c_BIT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]  r_wr;
    logic [c_ADDR_W-1:0]  r_rd;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_nxt;

    logic w_frame_end;
    logic w_good;
    logic w_full_now;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_frame_end = (r_state == ST_END);
    assign w_good      = w_frame_end & ~r_allzero & ~r_ferr & ~r_perr;
    assign w_full_now  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop       = Read_Done & (r_count != '0);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push      = w_good & (~w_full_now | w_pop);
    assign w_drop      = w_good & w_full_now & ~w_pop;
    assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    // Storage has no reset; only pointers and count define its contents.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr] <= r_shreg;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr          <= '0;
            r_rd          <= '0;
            r_count       <= '0;
            Data_Out      <= '0;
            Data_Rdy      <= 1'b0;
            Rx_Error      <= 3'b000;
            RTS           <= 1'b1;
            FIFO_Empty    <= 1'b1;
            FIFO_Full     <= 1'b0;
            FIFO_Overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                Data_Out <= r_mem[r_rd];
                r_rd     <= r_rd + c_ADDR_W'(1);
            end
            Data_Rdy <= w_pop;
            r_count  <= w_count_nxt;

            // Status flags follow the post-edge count.
            RTS        <= (w_count_nxt < c_CNT_W'(FIFO_DEPTH));
            FIFO_Empty <= (w_count_nxt == '0);
            FIFO_Full  <= (w_count_nxt > c_CNT_W'(FIFO_DEPTH / 2));

            if (w_drop) begin
                FIFO_Overflow <= 1'b1;
            end

            if (w_frame_end) begin
                Rx_Error <= r_allzero ? 3'b001 : {r_ferr, r_perr, 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo (8 data bits, even
//               parity, 2 stop bits, 8-entry FIFO). Directed table of frames,
//               hand-written corner sequences and a randomized run checked
//               against a frame-level reference model (byte queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_DEPTH = 8;

    logic       Clk;
    logic       Rst;
    logic       Rx;
    logic       Read_Done;
    logic [7:0] Data_Out;
    logic       Data_Rdy;
    logic [2:0] Rx_Error;
    logic       RTS;
    logic       FIFO_Empty;
    logic       FIFO_Full;
    logic       FIFO_Overflow;

    uart_rx_fifo #(
        .DATA_BITS (8),
        .PARITY_BIT(1),
        .STOP_BITS (2),
        .FIFO_DEPTH(c_DEPTH)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Rx           (Rx),
        .Read_Done    (Read_Done),
        .Data_Out     (Data_Out),
        .Data_Rdy     (Data_Rdy),
        .Rx_Error     (Rx_Error),
        .RTS          (RTS),
        .FIFO_Empty   (FIFO_Empty),
        .FIFO_Full    (FIFO_Full),
        .FIFO_Overflow(FIFO_Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bytes held in the FIFO, sticky overflow, last pop.
    logic [7:0] m_q[$];
    logic       m_ovf;
    logic [7:0] m_last;

    typedef struct {
        logic [7:0] data;
        bit         flip_par;
        logic [1:0] stops;
        logic [2:0] exp_err;
        bit         exp_push;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples on the next rise.
    task automatic step(input logic rx, input logic rd);
        @(negedge Clk);
        Rx        = rx;
        Read_Done = rd;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip_par, input logic [1:0] stops);
        step(1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) step(d[i], 1'b0);
        step((^d) ^ flip_par, 1'b0);
        step(stops[1], 1'b0);
        step(stops[0], 1'b0);
    endtask

    // Error code from the frame rules: break if every bit was 0, otherwise
    // frame error on any low stop bit and parity error on a wrong parity bit.
    function automatic logic [2:0] model_err(input logic [7:0] d, input bit flip_par,
                                             input logic [1:0] stops);
        logic par;
        par = (^d) ^ flip_par;
        if (d == 8'h00 && par == 1'b0 && stops == 2'b00) return 3'b001;
        return {(stops != 2'b11), flip_par, 1'b0};
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, ".empty"}, FIFO_Empty, (m_q.size() == 0));
        chk({tag, ".rts"},   RTS,        (m_q.size() < c_DEPTH));
        chk({tag, ".full"},  FIFO_Full,  (m_q.size() > c_DEPTH / 2));
        chk({tag, ".ovf"},   FIFO_Overflow, m_ovf);
    endtask

    // Full frame plus two idle cycles, then compare against the model.
    task automatic frame_expect(input string tag, input logic [7:0] d, input bit flip_par,
                                input logic [1:0] stops);
        logic [2:0] e;
        send_frame(d, flip_par, stops);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        e = model_err(d, flip_par, stops);
        chk({tag, ".err"}, Rx_Error, e);
        if (e == 3'b000) begin
            if (m_q.size() < c_DEPTH) m_q.push_back(d);
            else                      m_ovf = 1'b1;
        end
        check_flags(tag);
    endtask

    task automatic pop_expect(input string tag);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        if (m_q.size() > 0) begin
            m_last = m_q.pop_front();
            chk({tag, ".rdy"}, Data_Rdy, 1'b1);
        end else begin
            chk({tag, ".rdy"}, Data_Rdy, 1'b0);
        end
        chk({tag, ".dout"}, Data_Out, m_last);
        check_flags(tag);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1; Rx = 1'b1; Read_Done = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_last = 8'h00;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".dout"}, Data_Out, 8'h00);
        chk({tag, ".rdy"},  Data_Rdy, 1'b0);
        chk({tag, ".err"},  Rx_Error, 3'b000);
        chk({tag, ".rts"},  RTS, 1'b1);
        chk({tag, ".empty"}, FIFO_Empty, 1'b1);
        chk({tag, ".full"}, FIFO_Full, 1'b0);
        chk({tag, ".ovf"},  FIFO_Overflow, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         fp;
        logic [1:0] st;

        tbl[0] = '{8'hA5, 1'b0, 2'b11, 3'b000, 1'b1};
        tbl[1] = '{8'hAA, 1'b1, 2'b11, 3'b010, 1'b0};
        tbl[2] = '{8'h3C, 1'b0, 2'b11, 3'b000, 1'b1};
        tbl[3] = '{8'hAA, 1'b0, 2'b00, 3'b100, 1'b0};
        tbl[4] = '{8'h55, 1'b0, 2'b11, 3'b000, 1'b1};
        tbl[5] = '{8'h0F, 1'b1, 2'b10, 3'b110, 1'b0};

        Rst = 1'b1; Rx = 1'b1; Read_Done = 1'b0;
        do_reset();
        check_reset_values("reset");

        // Directed table: each frame alone, popped when accepted.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].data, tbl[i].flip_par, tbl[i].stops);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            chk($sformatf("tbl%0d.err", i), Rx_Error, tbl[i].exp_err);
            chk($sformatf("tbl%0d.empty", i), FIFO_Empty, !tbl[i].exp_push);
            if (tbl[i].exp_push) begin
                step(1'b1, 1'b1);
                step(1'b1, 1'b0);
                chk($sformatf("tbl%0d.rdy", i), Data_Rdy, 1'b1);
                chk($sformatf("tbl%0d.dout", i), Data_Out, tbl[i].data);
                chk($sformatf("tbl%0d.empty2", i), FIFO_Empty, 1'b1);
                step(1'b1, 1'b0);
                chk($sformatf("tbl%0d.rdy_pulse", i), Data_Rdy, 1'b0);
            end
        end
        m_last = 8'h55;

        // Break: 12 zero bits then 5 more low cycles, then long idle.
        send_frame(8'h00, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        chk("brk.err", Rx_Error, 3'b001);
        chk("brk.empty", FIFO_Empty, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        chk("brk.err_hold", Rx_Error, 3'b001);
        chk("brk.empty_hold", FIFO_Empty, 1'b1);
        frame_expect("brk.next", 8'h01, 1'b0, 2'b11);
        pop_expect("brk.pop");

        // Fill to capacity, overflow, drain in order.
        for (int i = 0; i < 8; i++) begin
            frame_expect($sformatf("fill%0d", i), 8'(i), 1'b0, 2'b11);
        end
        frame_expect("ovf", 8'hFF, 1'b0, 2'b11);
        for (int i = 0; i < 8; i++) pop_expect($sformatf("drain%0d", i));
        pop_expect("pop_empty");

        // Push at full coinciding with a pop: both succeed, no overflow.
        do_reset();
        for (int i = 0; i < 8; i++) frame_expect($sformatf("refill%0d", i), 8'h10 + 8'(i), 1'b0, 2'b11);
        send_frame(8'h99, 1'b0, 2'b11);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("pp.rdy", Data_Rdy, 1'b1);
        chk("pp.dout", Data_Out, 8'h10);
        chk("pp.ovf", FIFO_Overflow, 1'b0);
        chk("pp.rts", RTS, 1'b0);
        void'(m_q.pop_front());
        m_q.push_back(8'h99);
        m_last = 8'h10;
        for (int i = 0; i < 8; i++) pop_expect($sformatf("pp_drain%0d", i));

        // Reset mid-frame with a byte already buffered.
        frame_expect("pre_rst", 8'h42, 1'b0, 2'b11);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        do_reset();
        check_reset_values("midrst");
        frame_expect("post_rst", 8'h81, 1'b0, 2'b11);
        pop_expect("post_rst.pop");

        // Randomized frames with interleaved pops.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            d  = 8'($urandom);
            fp = ($urandom_range(0, 4) == 0);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 9) == 0) begin
                d = 8'h00; fp = 1'b0; st = 2'b00;
            end
            frame_expect($sformatf("rnd%0d", n), d, fp, st);
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_expect($sformatf("rnd%0d.pop", n));
        end
        while (m_q.size() > 0) pop_expect("rnd.drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
